// File: rtl/keyboard_pkg.sv
// keyboard_pkg
// Shared types and constants for the keyboard direction tracker:
//   key_state_t        per-key typematic FSM state
//   SC_*               PS/2 set-2 scan codes of the arrow keys
//   KEY_CODES_DEFAULT  packed code table, key i in bits [8i+7:8i]
package keyboard_pkg;

  typedef enum logic [1:0] {
    K_IDLE,
    K_DELAY,
    K_REPEAT
  } key_state_t;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Index 0 sits in the low byte: up=0, down=1, left=2, right=3.
  localparam logic [31:0] KEY_CODES_DEFAULT = {SC_RIGHT, SC_LEFT, SC_DOWN, SC_UP};

endpackage

// File: rtl/key_repeat_unit.sv
// key_repeat_unit
// One key's typematic engine: FSM, repeat counter, held level and press pulse.
// Ports:
//   clk        clock (posedge)
//   reset      synchronous, active-high
//   hit_make   one-cycle make event for this key
//   hit_break  one-cycle break event for this key
//   held       high while the key is down (registered state)
//   press      one-cycle pulse on initial press and on each repeat (registered)
module key_repeat_unit
  import keyboard_pkg::*;
#(
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic hit_make,
  input  logic hit_break,
  output logic held,
  output logic press
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DELAY_LD  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PERIOD_LD = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // A pulse is due on the edge where the counter steps from 1 to 0, which
  // places it exactly DELAY (or PERIOD) cycles after the previous pulse.
  logic expire;
  assign expire = (cnt_q == CNT_ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      K_IDLE: begin
        if (hit_make) begin
          state_d = K_DELAY;
          cnt_d   = DELAY_LD;
          press_d = 1'b1;
        end
      end
      K_DELAY: begin
        // Break is checked first so it beats a coincident expiry.
        if (hit_break) begin
          state_d = K_IDLE;
          cnt_d   = '0;
        end else if (REPEAT_EN) begin
          if (expire) begin
            state_d = K_REPEAT;
            cnt_d   = PERIOD_LD;
            press_d = 1'b1;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      K_REPEAT: begin
        if (hit_break) begin
          state_d = K_IDLE;
          cnt_d   = '0;
        end else if (expire) begin
          cnt_d   = PERIOD_LD;
          press_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = K_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= K_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign held  = (state_q != K_IDLE);
  assign press = press_q;

endmodule

// File: rtl/keyboard_dir_tracker.sv
// keyboard_dir_tracker
// Maps PS/2 make/break events onto NUM_KEYS configured scan codes, producing
// per-key held levels and press pulses (with optional auto-repeat), and tracks
// the most recently pressed key as the active direction.
// Ports:
//   CLOCK_50   clock (posedge)
//   reset      synchronous, active-high
//   ev_valid   one-cycle event strobe
//   makeBreak  1 = make, 0 = break
//   scan_code  event key code
//   held       per-key down level
//   press      per-key one-cycle press/repeat pulse
//   dir_valid  at least one mapped key is held
//   dir_idx    index of the active key (meaningful when dir_valid=1)
module keyboard_dir_tracker
  import keyboard_pkg::*;
#(
  parameter int                    NUM_KEYS      = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES     = KEY_CODES_DEFAULT,
  parameter bit                    REPEAT_EN     = 1'b1,
  parameter int                    REPEAT_DELAY  = 25_000_000,
  parameter int                    REPEAT_PERIOD = 5_000_000
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        ev_valid,
  input  logic                        makeBreak,
  input  logic [7:0]                  scan_code,
  output logic [NUM_KEYS-1:0]         held,
  output logic [NUM_KEYS-1:0]         press,
  output logic                        dir_valid,
  output logic [$clog2(NUM_KEYS)-1:0] dir_idx
);

  localparam int IDX_W = $clog2(NUM_KEYS);

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  logic                hit_any;
  logic [IDX_W-1:0]    hit_idx;
  logic [NUM_KEYS-1:0] hit_make, hit_break;
  logic [NUM_KEYS-1:0] remaining;
  logic                dir_valid_q, dir_valid_d;
  logic [IDX_W-1:0]    dir_idx_q, dir_idx_d;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (scan_code == KEY_CODES[8*i +: 8]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    hit_make  = '0;
    hit_break = '0;
    if (ev_valid && hit_any) begin
      if (makeBreak) hit_make[hit_idx]  = 1'b1;
      else           hit_break[hit_idx] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_repeat_unit #(
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_key (
      .clk      (CLOCK_50),
      .reset    (reset),
      .hit_make (hit_make[g]),
      .hit_break(hit_break[g]),
      .held     (held[g]),
      .press    (press[g])
    );
  end

  // held reflects the state before this edge, so "make & ~held" is exactly a
  // key leaving IDLE, and "break & held" is a real release. A released active
  // key falls back to the lowest-index key still down.
  always_comb begin
    dir_valid_d = dir_valid_q;
    dir_idx_d   = dir_idx_q;
    remaining   = held & ~hit_break;
    if (|(hit_make & ~held)) begin
      dir_valid_d = 1'b1;
      dir_idx_d   = hit_idx;
    end else if (|(hit_break & held) && (hit_idx == dir_idx_q)) begin
      dir_valid_d = |remaining;
      if (|remaining) dir_idx_d = lowest_set(remaining);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      dir_valid_q <= 1'b0;
      dir_idx_q   <= '0;
    end else begin
      dir_valid_q <= dir_valid_d;
      dir_idx_q   <= dir_idx_d;
    end
  end

  assign dir_valid = dir_valid_q;
  assign dir_idx   = dir_idx_q;

endmodule

// File: tb/tb_keyboard_dir_tracker.sv
// tb_keyboard_dir_tracker
// Directed bench for keyboard_dir_tracker. Two instances share the event bus:
// dut_a has auto-repeat enabled, dut_b has REPEAT_EN=0. Both use
// REPEAT_DELAY=8 and REPEAT_PERIOD=3.
module tb_keyboard_dir_tracker;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       ev_valid = 1'b0;
  logic       makeBreak = 1'b0;
  logic [7:0] scan_code = 8'h00;

  logic [3:0] held_a, press_a, held_b, press_b;
  logic       dir_valid_a, dir_valid_b;
  logic [1:0] dir_idx_a, dir_idx_b;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  keyboard_dir_tracker #(
    .REPEAT_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .ev_valid(ev_valid),
    .makeBreak(makeBreak), .scan_code(scan_code),
    .held(held_a), .press(press_a), .dir_valid(dir_valid_a), .dir_idx(dir_idx_a)
  );

  keyboard_dir_tracker #(
    .REPEAT_EN(1'b0), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .ev_valid(ev_valid),
    .makeBreak(makeBreak), .scan_code(scan_code),
    .held(held_b), .press(press_b), .dir_valid(dir_valid_b), .dir_idx(dir_idx_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic mb, input logic [7:0] sc);
    ev_valid  = 1'b1;
    makeBreak = mb;
    scan_code = sc;
    tick();
    ev_valid  = 1'b0;
    makeBreak = 1'b0;
    scan_code = 8'h00;
  endtask

  initial begin
    // Reset held for two cycles with random event traffic
    for (int i = 0; i < 2; i++) begin
      ev_valid  = 1'($urandom);
      makeBreak = 1'($urandom);
      scan_code = 8'($urandom);
      tick();
    end
    check("rst_held",      held_a,      0);
    check("rst_press",     press_a,     0);
    check("rst_dir_valid", dir_valid_a, 0);
    check("rst_dir_idx",   dir_idx_a,   0);
    check("rst_held_b",    held_b,      0);
    reset     = 1'b0;
    ev_valid  = 1'b0;
    makeBreak = 1'b0;
    scan_code = 8'h00;
    tick();
    check("idle_press", press_a, 0);

    // Tap: make up, break four cycles later
    send(1'b1, 8'h75);
    check("tap_press_T",  press_a,     4'b0001);
    check("tap_held_T",   held_a,      4'b0001);
    check("tap_dvalid_T", dir_valid_a, 1);
    check("tap_didx_T",   dir_idx_a,   0);
    for (int t = 1; t < 4; t++) begin
      tick();
      check("tap_press_hold", press_a,     0);
      check("tap_held_hold",  held_a,      4'b0001);
      check("tap_dvalid",     dir_valid_a, 1);
    end
    send(1'b0, 8'h75);
    check("tap_held_brk",   held_a,      0);
    check("tap_dvalid_brk", dir_valid_a, 0);
    check("tap_press_brk",  press_a,     0);
    for (int t = 0; t < 10; t++) begin
      tick();
      check("tap_no_repeat", press_a, 0);
    end

    // Hold right 20 cycles, keyboard re-sends make every 5 cycles
    send(1'b1, 8'h74);
    check("rep_press_T", press_a,   4'b1000);
    check("rep_didx_T",  dir_idx_a, 3);
    for (int t = 1; t < 20; t++) begin
      if (t % 5 == 0) begin
        ev_valid  = 1'b1;
        makeBreak = 1'b1;
        scan_code = 8'h74;
      end
      tick();
      ev_valid  = 1'b0;
      makeBreak = 1'b0;
      scan_code = 8'h00;
      check("rep_press", press_a, (t == 8 || t == 11 || t == 14 || t == 17) ? 4'b1000 : 4'b0000);
      check("rep_held",  held_a,  4'b1000);
    end
    // Cycle T+20 is also an expiry; the break must suppress it
    send(1'b0, 8'h74);
    check("rep_brk_press", press_a, 0);
    check("rep_brk_held",  held_a,  0);
    tick();
    check("rep_after_brk", press_a, 0);

    // Break lands on the first expiry (T+8)
    send(1'b1, 8'h74);
    check("coin_press_T", press_a, 4'b1000);
    for (int t = 1; t < 8; t++) begin
      tick();
      check("coin_press_wait", press_a, 0);
    end
    send(1'b0, 8'h74);
    check("coin_press", press_a,     0);
    check("coin_held",  held_a,      0);
    check("coin_dval",  dir_valid_a, 0);
    for (int t = 0; t < 4; t++) begin
      tick();
      check("coin_after", press_a, 0);
    end

    // Last pressed wins and fallback
    send(1'b1, 8'h6B);
    check("lpw_left_idx",  dir_idx_a,   2);
    check("lpw_left_val",  dir_valid_a, 1);
    check("lpw_left_held", held_a,      4'b0100);
    send(1'b1, 8'h75);
    check("lpw_up_idx",  dir_idx_a, 0);
    check("lpw_up_held", held_a,    4'b0101);
    send(1'b0, 8'h75);
    check("lpw_fallback_idx", dir_idx_a,   2);
    check("lpw_fallback_val", dir_valid_a, 1);
    check("lpw_fallback_hld", held_a,      4'b0100);
    send(1'b0, 8'h6B);
    check("lpw_none_val",  dir_valid_a, 0);
    check("lpw_none_held", held_a,      0);
    send(1'b0, 8'h74);
    check("lpw_ghost_val",   dir_valid_a, 0);
    check("lpw_ghost_idx",   dir_idx_a,   2);
    check("lpw_ghost_held",  held_a,      0);
    check("lpw_ghost_press", press_a,     0);

    // REPEAT_EN=0: unmapped code, long hold, reset mid-hold
    send(1'b1, 8'h1C);
    check("ne_unmapped_held",  held_b,      0);
    check("ne_unmapped_press", press_b,     0);
    check("ne_unmapped_val",   dir_valid_b, 0);
    check("ne_unmapped_idx",   dir_idx_b,   2);
    send(1'b1, 8'h72);
    check("ne_press_T", press_b,     4'b0010);
    check("ne_held_T",  held_b,      4'b0010);
    check("ne_dval_T",  dir_valid_b, 1);
    check("ne_didx_T",  dir_idx_b,   1);
    for (int t = 1; t < 30; t++) begin
      tick();
      check("ne_press_hold", press_b, 0);
      check("ne_held_hold",  held_b,  4'b0010);
    end
    reset = 1'b1;
    tick();
    check("mid_rst_held_b",  held_b,      0);
    check("mid_rst_press_b", press_b,     0);
    check("mid_rst_dval_b",  dir_valid_b, 0);
    check("mid_rst_didx_b",  dir_idx_b,   0);
    check("mid_rst_held_a",  held_a,      0);
    check("mid_rst_press_a", press_a,     0);
    reset = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      check("post_rst_press_a", press_a, 0);
      check("post_rst_press_b", press_b, 0);
      check("post_rst_held_a",  held_a,  0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
